// File: rtl/parser_arb_pkg.sv
// Shared types and widths for the parser feed arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default message/object widths, arbiter FSM state encoding, order-object type.
package parser_arb_pkg;

  localparam int MSG_W = 320;
  localparam int OBJ_W = 162;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef logic [OBJ_W-1:0] obj_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: selects the first requesting index at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken this cycle.
// Ports: req_i (one bit per requester), ptr_i (search start), grant_idx_o (winner), any_o (some request set).
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = '0;
    // Walk from the farthest offset back towards ptr so the nearest request is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (req_i[cand]) begin
        grant_idx_o = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parser_feed_arbiter.sv
// Shares one order_book_parser between NUM_FEEDS feed buffers, round-robin, one message in flight.
// Latency: pop and parser request visible the cycle after grant; obj_valid the cycle after parser_ready.
// Backpressure: obj_ready low holds DONE (no new grant); parser silence past PARSE_TIMEOUT drops the message.
// Ports: feed_valid/feed_msg/feed_pop (ingress FIFOs), parser_buffer_* / parser_out_object / parser_ready
//        (parser), obj_valid/obj_data/obj_src/obj_ready (downstream), timeout_err, msg_count (status).
module parser_feed_arbiter #(
  parameter int NUM_FEEDS     = 4,
  parameter int MSG_W         = parser_arb_pkg::MSG_W,
  parameter int OBJ_W         = parser_arb_pkg::OBJ_W,
  parameter int PARSE_TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_FEEDS-1:0]         feed_valid,
  input  logic [NUM_FEEDS*MSG_W-1:0]   feed_msg,
  output logic [NUM_FEEDS-1:0]         feed_pop,
  output logic                         parser_buffer_not_empty,
  output logic [MSG_W-1:0]             parser_buffer_text,
  input  logic [OBJ_W-1:0]             parser_out_object,
  input  logic                         parser_ready,
  output logic                         obj_valid,
  output logic [OBJ_W-1:0]             obj_data,
  output logic [$clog2(NUM_FEEDS)-1:0] obj_src,
  input  logic                         obj_ready,
  output logic                         timeout_err,
  output logic [15:0]                  msg_count
);

  import parser_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_FEEDS);
  localparam int TMR_W = $clog2(PARSE_TIMEOUT);

  arb_state_t           state_q;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     src_q;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [MSG_W-1:0]     msg_q;
  logic [OBJ_W-1:0]     obj_q;
  logic [TMR_W-1:0]     timer_q;
  logic [15:0]          msg_count_q, msg_count_d;
  logic [NUM_FEEDS-1:0] pop_q;
  logic                 req_q;
  logic                 obj_vld_q;
  logic                 timeout_q;
  logic [MSG_W-1:0]     feed_slice [NUM_FEEDS];

  for (genvar g = 0; g < NUM_FEEDS; g++) begin : g_slice
    assign feed_slice[g] = feed_msg[g*MSG_W +: MSG_W];
  end

  rr_picker #(
    .N     (NUM_FEEDS),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req_i       (feed_valid),
    .ptr_i       (rr_ptr_q),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  // After a message finishes (delivered or dropped) the search restarts just past its source.
  assign rr_ptr_d    = (src_q == IDX_W'(NUM_FEEDS - 1)) ? '0 : src_q + 1'b1;
  assign msg_count_d = msg_count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      src_q       <= '0;
      msg_q       <= '0;
      obj_q       <= '0;
      timer_q     <= '0;
      msg_count_q <= '0;
      pop_q       <= '0;
      req_q       <= 1'b0;
      obj_vld_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      pop_q     <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            msg_q   <= feed_slice[grant_idx];
            src_q   <= grant_idx;
            pop_q   <= NUM_FEEDS'(1) << grant_idx;
            req_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A ready arriving on the last allowed cycle still counts; the timeout branch is the fallback.
          if (parser_ready) begin
            obj_q     <= parser_out_object;
            req_q     <= 1'b0;
            obj_vld_q <= 1'b1;
            state_q   <= DONE;
          end else if (timer_q == TMR_W'(PARSE_TIMEOUT - 1)) begin
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE: begin
          if (obj_ready) begin
            obj_vld_q   <= 1'b0;
            msg_count_q <= msg_count_d;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign feed_pop                = pop_q;
  assign parser_buffer_not_empty = req_q;
  assign parser_buffer_text      = msg_q;
  assign obj_valid               = obj_vld_q;
  assign obj_data                = obj_q;
  assign obj_src                 = src_q;
  assign timeout_err             = timeout_q;
  assign msg_count               = msg_count_q;

endmodule

// File: tb/tb_parser_feed_arbiter.sv
// Self-checking bench for parser_feed_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
// Ends with a single summary line.
module tb_parser_feed_arbiter;

  import parser_arb_pkg::*;

  localparam int N  = 4;
  localparam int PT = 8;
  localparam int IW = $clog2(N);

  localparam logic [MSG_W-1:0] MSG2 = {16'h4478, 304'h0};
  localparam logic [OBJ_W-1:0] OBJ2 = {2'b10, 32'hCAFE_F00D, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677};
  localparam logic [OBJ_W-1:0] OBJ5 = {2'b01, 32'h1234_5678, 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100};

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         feed_valid;
  logic [N*MSG_W-1:0]   feed_msg;
  logic [N-1:0]         feed_pop;
  logic                 parser_buffer_not_empty;
  logic [MSG_W-1:0]     parser_buffer_text;
  logic [OBJ_W-1:0]     parser_out_object;
  logic                 parser_ready;
  logic                 obj_valid;
  logic [OBJ_W-1:0]     obj_data;
  logic [IW-1:0]        obj_src;
  logic                 obj_ready;
  logic                 timeout_err;
  logic [15:0]          msg_count;

  int vectors = 0;
  int errs    = 0;

  parser_feed_arbiter #(
    .NUM_FEEDS     (N),
    .MSG_W         (MSG_W),
    .OBJ_W         (OBJ_W),
    .PARSE_TIMEOUT (PT)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .feed_valid              (feed_valid),
    .feed_msg                (feed_msg),
    .feed_pop                (feed_pop),
    .parser_buffer_not_empty (parser_buffer_not_empty),
    .parser_buffer_text      (parser_buffer_text),
    .parser_out_object       (parser_out_object),
    .parser_ready            (parser_ready),
    .obj_valid               (obj_valid),
    .obj_data                (obj_data),
    .obj_src                 (obj_src),
    .obj_ready               (obj_ready),
    .timeout_err             (timeout_err),
    .msg_count               (msg_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic rand_msgs();
    for (int w = 0; w < N * MSG_W / 32; w++) feed_msg[w*32 +: 32] = $urandom();
  endtask

  function automatic logic [OBJ_W-1:0] rand_obj();
    return OBJ_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // ---------------- transaction-level model ----------------
  // One message at a time: a grant starts it, the parser has PT looks to answer,
  // then the object waits for downstream. Updated on each rising edge from the inputs.
  bit             m_live = 1'b0;
  bit             m_busy, m_have, m_to;
  int             m_age, m_ptr, m_src;
  logic [N-1:0]   m_pop;
  logic [MSG_W-1:0] m_msg;
  logic [OBJ_W-1:0] m_obj;
  logic [15:0]    m_count;

  initial begin
    logic [IW-1:0] f;
    bit found;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_live = 1'b1; m_busy = 1'b0; m_have = 1'b0; m_to = 1'b0;
        m_age = 0; m_ptr = 0; m_src = 0; m_pop = '0;
        m_msg = '0; m_obj = '0; m_count = '0;
      end else begin
        m_pop = '0;
        m_to  = 1'b0;
        if (!m_busy) begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            f = IW'((m_ptr + k) % N);
            if (!found && feed_valid[f]) begin
              found  = 1'b1;
              m_busy = 1'b1;
              m_age  = 0;
              m_src  = int'(f);
              m_msg  = feed_msg[f*MSG_W +: MSG_W];
              m_pop  = N'(1) << f;
            end
          end
        end else if (m_have) begin
          if (obj_ready) begin
            m_count = m_count + 16'd1;
            m_ptr   = (m_src + 1) % N;
            m_busy  = 1'b0;
            m_have  = 1'b0;
          end
        end else if (m_age == 0) begin
          m_age = 1;                     // request cycle: parser answer not looked at yet
        end else if (parser_ready) begin
          m_have = 1'b1;
          m_obj  = parser_out_object;
        end else if (m_age == PT) begin
          m_to   = 1'b1;
          m_busy = 1'b0;
          m_ptr  = (m_src + 1) % N;
        end else begin
          m_age++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("pop", feed_pop, m_pop);
        chk("req", parser_buffer_not_empty, m_busy && !m_have);
        chk("text", parser_buffer_text, m_msg);
        chk("obj_valid", obj_valid, m_have);
        chk("obj_data", obj_data, m_obj);
        chk("obj_src", obj_src, m_src);
        chk("timeout_err", timeout_err, m_to);
        chk("msg_count", msg_count, m_count);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] p;
    logic [N-1:0] got [$];
    logic [N-1:0] exp_order [6];
    int n;
    bit seen;

    reset = 1'b1; feed_valid = '1; feed_msg = '0;
    parser_out_object = '0; parser_ready = 1'b0; obj_ready = 1'b0;
    rand_msgs();

    // 1. reset held with every feed requesting
    repeat (3) begin
      tick();
      chk("t1_pop", feed_pop, 0);
      chk("t1_req", parser_buffer_not_empty, 0);
      chk("t1_vld", obj_valid, 0);
      chk("t1_cnt", msg_count, 0);
    end
    reset = 1'b0;

    // 2. single feed, parser answers two cycles after the request
    feed_valid = 4'b0100; feed_msg = '0; feed_msg[2*MSG_W +: MSG_W] = MSG2;
    obj_ready = 1'b1;
    tick();
    chk("t2_pop", feed_pop, 4'b0100);
    chk("t2_req", parser_buffer_not_empty, 1);
    chk("t2_text", parser_buffer_text, MSG2);
    feed_valid = '0;
    tick();
    chk("t2_single_pop", feed_pop, 0);
    parser_ready = 1'b1; parser_out_object = OBJ2;
    tick();
    parser_ready = 1'b0;
    chk("t2_vld", obj_valid, 1);
    chk("t2_src", obj_src, 2);
    chk("t2_obj", obj_data, OBJ2);
    chk("t2_req_low", parser_buffer_not_empty, 0);
    tick();
    chk("t2_cnt", msg_count, 1);
    chk("t2_vld_low", obj_valid, 0);

    // 3. all feeds busy: strict rotation
    do_reset(2);
    feed_valid = '1; parser_ready = 1'b1; obj_ready = 1'b1; rand_msgs();
    for (int c = 0; c < 80 && got.size() < 6; c++) begin
      tick();
      if (feed_pop != '0) got.push_back(feed_pop);
    end
    feed_valid = '0;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    chk("t3_grants", got.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), (i < got.size()) ? got[i] : '0, exp_order[i]);

    // 4. parser silent: timeout, then pointer moves past the dropped source
    do_reset(2);
    feed_valid = 4'b0010; parser_ready = 1'b0; obj_ready = 1'b1;
    p = '0;
    for (int c = 0; c < 20 && p == '0; c++) begin tick(); p = feed_pop; end
    chk("t4_pop", p, 4'b0010);
    feed_valid = '1;
    n = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick(); n++;
      if (timeout_err) seen = 1'b1;
    end
    chk("t4_timeout_seen", seen, 1);
    chk("t4_timeout_lat", n, PT + 1);
    chk("t4_no_vld", obj_valid, 0);
    tick();
    chk("t4_next_grant", feed_pop, 4'b0100);
    feed_valid = '0;

    // 5. downstream stalls in DONE while feed 1 waits
    do_reset(2);
    feed_valid = 4'b0011; parser_ready = 1'b1; parser_out_object = OBJ5; obj_ready = 1'b0;
    p = '0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (feed_pop != '0) begin p = feed_pop; feed_valid = 4'b0010; end
      if (obj_valid) seen = 1'b1;
    end
    chk("t5_first_pop", p, 4'b0001);
    chk("t5_vld", obj_valid, 1);
    chk("t5_obj", obj_data, OBJ5);
    repeat (5) begin
      parser_out_object = rand_obj();
      tick();
      chk("t5_hold_vld", obj_valid, 1);
      chk("t5_hold_obj", obj_data, OBJ5);
      chk("t5_hold_nopop", feed_pop, 0);
    end
    obj_ready = 1'b1;
    tick();
    chk("t5_released", obj_valid, 0);
    tick();
    chk("t5_feed1_grant", feed_pop, 4'b0010);
    feed_valid = '0; parser_ready = 1'b0;

    // 6. reset while waiting on the parser, then counter wrap
    do_reset(2);
    feed_valid = 4'b0001; parser_ready = 1'b0; obj_ready = 1'b1;
    p = '0;
    for (int c = 0; c < 20 && p == '0; c++) begin tick(); p = feed_pop; end
    chk("t6_pop", p, 4'b0001);
    feed_valid = '0;
    tick(); tick();
    chk("t6_in_wait", parser_buffer_not_empty, 1);
    do_reset(1);
    repeat (12) begin
      tick();
      chk("t6_abandon_vld", obj_valid, 0);
      chk("t6_abandon_pop", feed_pop, 0);
      chk("t6_abandon_req", parser_buffer_not_empty, 0);
    end
    #2;
    dut.msg_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    feed_valid = 4'b1000; parser_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (feed_pop != '0) feed_valid = '0;
      if (obj_valid) seen = 1'b1;
    end
    chk("t6_vld", obj_valid, 1);
    chk("t6_cnt_pre", msg_count, 16'hFFFF);
    tick();
    chk("t6_cnt_wrap", msg_count, 0);
    parser_ready = 1'b0;

    // randomized traffic, checked by the per-cycle compare
    do_reset(2);
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset             = ($urandom_range(0, 299) == 0);
      feed_valid        = N'($urandom());
      rand_msgs();
      parser_ready      = ($urandom_range(0, 6) == 0);
      parser_out_object = rand_obj();
      obj_ready         = $urandom_range(0, 1) == 1;
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
